// File: rtl/rst_seq_if.sv
// rst_seq_if: reset sequencer bus (request inputs, reset outputs, status); master drives requests, slave is the sequencer
interface rst_seq_if;
  logic       sw_rst_req;
  logic       wdog_rst_req;
  logic       pll_locked;
  logic       ext_rst_n;
  logic       core_rst_n;
  logic       seq_busy;
  logic [1:0] rst_cause;
  modport master (output sw_rst_req, wdog_rst_req, pll_locked, input ext_rst_n, core_rst_n, seq_busy, rst_cause);
  modport slave (input sw_rst_req, wdog_rst_req, pll_locked, output ext_rst_n, core_rst_n, seq_busy, rst_cause);
endinterface

// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer; ports clk, reset (sync active-high), bus (requests in, ext/core resets, busy, cause out)
module rst_seq #(
  parameter int PULSE_LEN = 1000,
  parameter int GAP_LEN   = 100,
  parameter int CNT_W     = 16
) (
  input logic        clk,
  input logic        reset,
  rst_seq_if.slave   bus
);
  typedef enum logic [1:0] {ASSERT, WAIT_LOCK, REL_EXT, RUN} state_t;
  localparam logic [CNT_W-1:0] P_TC = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] G_TC = CNT_W'(GAP_LEN - 1);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ev;
  logic [1:0]       cause_nx;
  always_comb begin
    ev       = bus.sw_rst_req | bus.wdog_rst_req | (!bus.pll_locked && (state == REL_EXT || state == RUN));
    cause_nx = bus.wdog_rst_req ? 2'b10 : bus.sw_rst_req ? 2'b01 : 2'b11;
    state_nx = ev                                    ? ASSERT    :
               (state == ASSERT && cnt == P_TC)      ? WAIT_LOCK :
               (state == WAIT_LOCK && bus.pll_locked) ? REL_EXT  :
               (state == REL_EXT && cnt == G_TC)     ? RUN       : state;
    // counter restarts on every state change or event, otherwise saturates
    cnt_nx   = (ev || state_nx != state) ? '0 : (&cnt ? cnt : cnt + 1'b1);
  end
  // outputs are registered from the next state so they match the state held in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ASSERT;
      cnt            <= '0;
      bus.ext_rst_n  <= 1'b0;
      bus.core_rst_n <= 1'b0;
      bus.seq_busy   <= 1'b1;
      bus.rst_cause  <= 2'b00;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      bus.ext_rst_n  <= state_nx == REL_EXT || state_nx == RUN;
      bus.core_rst_n <= state_nx == RUN;
      bus.seq_busy   <= state_nx != RUN;
      if (ev) bus.rst_cause <= cause_nx;
    end
  end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The module SHALL have parameter PULSE_LEN, default 1000, giving the number of cycles both reset outputs are held asserted per reset event (legal range 2 to 2^CNT_W-1).
REQ-002 The module SHALL have parameter GAP_LEN, default 100, giving the number of cycles between ext_rst_n release and core_rst_n release (legal range 1 to 2^CNT_W-1).
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the counter width.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset; both ports are listed below.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port sw_rst_req, input, 1 bit: software reset request, one-cycle pulse, synchronous to clk.
REQ-008 Port wdog_rst_req, input, 1 bit: watchdog reset request, one-cycle pulse, synchronous to clk.
REQ-009 Port pll_locked, input, 1 bit: PLL lock status, already synchronous to clk.
REQ-010 Port ext_rst_n, output, 1 bit: active-low reset driven to the external laser driver pin, registered.
REQ-011 Port core_rst_n, output, 1 bit: active-low reset for internal core logic, registered.
REQ-012 Port seq_busy, output, 1 bit: high in every state except RUN.
REQ-013 Port rst_cause, output, 2 bits: cause of the last reset event. 00 = power-on/reset, 01 = software, 10 = watchdog, 11 = lock loss.

Function
REQ-014 The FSM SHALL have exactly four states: ASSERT, WAIT_LOCK, REL_EXT and RUN.
REQ-015 Outputs SHALL be registered so that each output reflects the state occupied in that same cycle:
- ext_rst_n = 1 only in REL_EXT and RUN.
- core_rst_n = 1 only in RUN.
- seq_busy = 0 only in RUN.
REQ-016 ASSERT SHALL last exactly PULSE_LEN cycles, counted by a CNT_W-bit counter that starts at 0 on entry, and SHALL then go to WAIT_LOCK.
REQ-017 WAIT_LOCK SHALL stay until pll_locked = 1 is sampled, then go to REL_EXT with the counter cleared; WAIT_LOCK SHALL last at least one cycle.
REQ-018 REL_EXT SHALL last exactly GAP_LEN cycles and SHALL then go to RUN.
REQ-019 RUN SHALL be held indefinitely until a reset event occurs.
REQ-020 A reset event is any of:
- sw_rst_req = 1;
- wdog_rst_req = 1;
- pll_locked = 0 while in REL_EXT or RUN.
REQ-021 A reset event sampled in cycle N in any state SHALL put the FSM in ASSERT at cycle N+1 with the counter at 0; in ASSERT this restarts (stretches) the pulse.
REQ-022 pll_locked = 0 in ASSERT or WAIT_LOCK SHALL NOT count as a reset event.
REQ-023 rst_cause SHALL be updated in the cycle ASSERT is entered due to an event and held otherwise.
REQ-024 When events coincide, rst_cause priority SHALL be watchdog > software > lock loss.
REQ-025 The counter SHALL never wrap; it SHALL saturate at its terminal count in each state.

Reset
REQ-026 When reset = 1 is sampled, the next cycle SHALL have: state ASSERT, counter 0, ext_rst_n = 0, core_rst_n = 0, seq_busy = 1, rst_cause = 00.
REQ-027 reset SHALL take priority over all request inputs.
REQ-028 reset asserted mid-sequence SHALL restart the full sequence from ASSERT.
REQ-029 Request inputs SHALL be ignored while reset = 1.

Verification (PULSE_LEN = 8, GAP_LEN = 4, cycle 0 = first cycle after reset is released)
REQ-030 Power-up: hold pll_locked = 1 and release reset -> ext_rst_n rises at cycle 9, core_rst_n rises at cycle 13, seq_busy falls at cycle 13, rst_cause = 00.
REQ-031 Lock wait: hold pll_locked = 0 until cycle 20, then set it to 1 -> ext_rst_n rises at cycle 21, core_rst_n rises at cycle 25.
REQ-032 Watchdog in RUN: wdog_rst_req pulse at cycle N -> both outputs low at N+1, rst_cause = 10, ext_rst_n rises at N+10.
REQ-033 Retrigger: sw_rst_req pulse in the 5th cycle of ASSERT -> ASSERT extends to 8 cycles counted from the restart, rst_cause = 01.
REQ-034 Simultaneous events: sw_rst_req, wdog_rst_req and pll_locked = 0 all in the same RUN cycle -> rst_cause = 10.
REQ-035 Lock loss in REL_EXT: pll_locked = 0 in REL_EXT -> ext_rst_n low the next cycle, rst_cause = 11; mid-sequence reset -> outputs low the next cycle and rst_cause = 00.
